// File: rtl/al_ready_commit_pkg.sv
// Shared constants, state encoding and helpers for the active-list ready-bit commit logic.
package al_ready_commit_pkg;

    localparam int DEPTH        = 128;
    localparam int INDEX        = 7;
    localparam int COMMIT_WIDTH = 4;
    localparam int WIDTH        = 2;
    localparam int CNT_W        = 3;
    localparam int AL_READY_BIT = 0;
    localparam int AL_EXC_BIT   = 1;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        EXC  = 2'd2
    } alCommitState_t;

    function automatic logic [CNT_W-1:0] lane_popcount(input logic [COMMIT_WIDTH-1:0] vec);
        logic [CNT_W-1:0] sum;
        sum = {CNT_W{1'b0}};
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            sum = sum + CNT_W'(vec[k]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/al_ready_commit_prefix.sv
// Combinational retire decision: length of the ready, exception-free prefix of the head window.
module al_ready_prefix
    import al_ready_commit_pkg::*;
(
    input  logic [COMMIT_WIDTH*WIDTH-1:0] entries,
    input  logic [CNT_W-1:0]              avail_cnt,
    input  logic                          stall,
    output logic [CNT_W-1:0]              commit_cnt,
    output logic [COMMIT_WIDTH-1:0]       clr_mask,
    output logic                          exc_head
);

    logic             run_s;
    logic [WIDTH-1:0] entry_s;

    // Walk lanes from the head; the first non-retirable entry ends the group.
    always_comb begin
        run_s      = ~stall;
        entry_s    = {WIDTH{1'b0}};
        commit_cnt = {CNT_W{1'b0}};
        clr_mask   = {COMMIT_WIDTH{1'b0}};
        exc_head   = ~stall && (avail_cnt != {CNT_W{1'b0}}) &&
                     entries[AL_READY_BIT] && entries[AL_EXC_BIT];
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            entry_s = entries[k*WIDTH +: WIDTH];
            if (run_s && (CNT_W'(k) < avail_cnt) &&
                entry_s[AL_READY_BIT] && !entry_s[AL_EXC_BIT]) begin
                clr_mask[k] = 1'b1;
                commit_cnt  = CNT_W'(k + 1);
            end else begin
                run_s = 1'b0;
            end
        end
    end

endmodule

// File: rtl/al_ready_commit.sv
// Commit-side reader/clearer for the active-list ready-bit RAM: sweeps after reset/flush,
// then retires contiguous ready entries from the head and reports head exceptions.
module al_ready_commit
    import al_ready_commit_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush_i,
    input  logic                          stall_i,
    input  logic [INDEX:0]                alCount_i,
    input  logic [COMMIT_WIDTH-1:0]       laneActive_i,
    output logic [COMMIT_WIDTH*INDEX-1:0] rdAddr_o,
    input  logic [COMMIT_WIDTH*WIDTH-1:0] rdData_i,
    output logic [COMMIT_WIDTH-1:0]       clrWe_o,
    output logic [COMMIT_WIDTH*INDEX-1:0] clrAddr_o,
    output logic [COMMIT_WIDTH*WIDTH-1:0] clrData_o,
    output logic [COMMIT_WIDTH-1:0]       commitVec_o,
    output logic [CNT_W-1:0]              commitCnt_o,
    output logic [INDEX-1:0]              headPtr_o,
    output logic                          exception_o,
    output logic [INDEX-1:0]              excPtr_o,
    output logic                          ready_o
);

    alCommitState_t            state_r;
    logic [INDEX:0]            sweep_ptr_r;
    logic [INDEX-1:0]          head_r;
    logic [COMMIT_WIDTH-1:0]   commit_vec_r;
    logic [CNT_W-1:0]          commit_cnt_r;
    logic                      exception_r;
    logic [INDEX-1:0]          exc_ptr_r;
    logic                      ready_r;

    logic [CNT_W-1:0]          lane_cnt_s;
    logic [CNT_W-1:0]          avail_cnt_s;
    logic                      prefix_stall_s;
    logic [CNT_W-1:0]          commit_cnt_s;
    logic [COMMIT_WIDTH-1:0]   clr_mask_s;
    logic                      exc_head_s;
    logic [INDEX:0]            sweep_next_s;
    logic [INDEX-1:0]          clr_base_s;

    assign lane_cnt_s     = lane_popcount(laneActive_i);
    assign sweep_next_s   = sweep_ptr_r + (INDEX+1)'(lane_cnt_s);
    assign prefix_stall_s = stall_i || (state_r != RUN);

    // Retire window size: the smaller of valid entries and active lanes.
    always_comb begin
        if (alCount_i < (INDEX+1)'(lane_cnt_s)) begin
            avail_cnt_s = alCount_i[CNT_W-1:0];
        end else begin
            avail_cnt_s = lane_cnt_s;
        end
    end

    al_ready_prefix u_prefix (
        .entries    (rdData_i),
        .avail_cnt  (avail_cnt_s),
        .stall      (prefix_stall_s),
        .commit_cnt (commit_cnt_s),
        .clr_mask   (clr_mask_s),
        .exc_head   (exc_head_s)
    );

    // Clears target the sweep window during INIT and the head window otherwise.
    always_comb begin
        if (state_r == INIT) begin
            clr_base_s = sweep_ptr_r[INDEX-1:0];
        end else begin
            clr_base_s = head_r;
        end
    end

    // Per-lane read and clear addresses; INDEX-bit arithmetic wraps at DEPTH.
    always_comb begin
        rdAddr_o  = {(COMMIT_WIDTH*INDEX){1'b0}};
        clrAddr_o = {(COMMIT_WIDTH*INDEX){1'b0}};
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            rdAddr_o[k*INDEX +: INDEX]  = head_r + INDEX'(k);
            clrAddr_o[k*INDEX +: INDEX] = clr_base_s + INDEX'(k);
        end
    end

    // Clear write enables per state.
    always_comb begin
        case (state_r)
            INIT:    clrWe_o = laneActive_i;
            RUN:     clrWe_o = clr_mask_s;
            EXC:     clrWe_o = {COMMIT_WIDTH{1'b0}};
            default: clrWe_o = {COMMIT_WIDTH{1'b0}};
        endcase
    end

    // Commit FSM with head/sweep pointers and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            state_r      <= INIT;
            sweep_ptr_r  <= {(INDEX+1){1'b0}};
            head_r       <= {INDEX{1'b0}};
            commit_vec_r <= {COMMIT_WIDTH{1'b0}};
            commit_cnt_r <= {CNT_W{1'b0}};
            exception_r  <= 1'b0;
            exc_ptr_r    <= {INDEX{1'b0}};
            ready_r      <= 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    sweep_ptr_r  <= sweep_next_s;
                    commit_vec_r <= {COMMIT_WIDTH{1'b0}};
                    commit_cnt_r <= {CNT_W{1'b0}};
                    if (sweep_next_s >= (INDEX+1)'(DEPTH)) begin
                        state_r <= RUN;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= INIT;
                    end
                end
                RUN: begin
                    head_r       <= head_r + INDEX'(commit_cnt_s);
                    commit_vec_r <= clr_mask_s;
                    commit_cnt_r <= commit_cnt_s;
                    if (exc_head_s) begin
                        state_r     <= EXC;
                        exception_r <= 1'b1;
                        exc_ptr_r   <= head_r;
                    end else begin
                        state_r <= RUN;
                    end
                end
                EXC: begin
                    commit_vec_r <= {COMMIT_WIDTH{1'b0}};
                    commit_cnt_r <= {CNT_W{1'b0}};
                end
                default: begin
                    state_r     <= INIT;
                    sweep_ptr_r <= {(INDEX+1){1'b0}};
                    ready_r     <= 1'b0;
                end
            endcase
        end
    end

    assign clrData_o   = {(COMMIT_WIDTH*WIDTH){1'b0}};
    assign commitVec_o = commit_vec_r;
    assign commitCnt_o = commit_cnt_r;
    assign headPtr_o   = head_r;
    assign exception_o = exception_r;
    assign excPtr_o    = exc_ptr_r;
    assign ready_o     = ready_r;

endmodule

// File: tb/tb_al_ready_commit.sv
// Directed bench for al_ready_commit with a behavioural 128x2 ready-bit RAM.
module tb_al_ready_commit;

    logic        clk;
    logic        reset;
    logic        flush_i;
    logic        stall_i;
    logic [7:0]  alCount_i;
    logic [3:0]  laneActive_i;
    logic [27:0] rdAddr_o;
    logic [7:0]  rdData_i;
    logic [3:0]  clrWe_o;
    logic [27:0] clrAddr_o;
    logic [7:0]  clrData_o;
    logic [3:0]  commitVec_o;
    logic [2:0]  commitCnt_o;
    logic [6:0]  headPtr_o;
    logic        exception_o;
    logic [6:0]  excPtr_o;
    logic        ready_o;

    logic [1:0]  ram [128];
    logic        fill_all;
    logic        set_en;
    logic [6:0]  set_addr;
    logic [1:0]  set_val;

    int checks;
    int failures;

    al_ready_commit dut (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (flush_i),
        .stall_i      (stall_i),
        .alCount_i    (alCount_i),
        .laneActive_i (laneActive_i),
        .rdAddr_o     (rdAddr_o),
        .rdData_i     (rdData_i),
        .clrWe_o      (clrWe_o),
        .clrAddr_o    (clrAddr_o),
        .clrData_o    (clrData_o),
        .commitVec_o  (commitVec_o),
        .commitCnt_o  (commitCnt_o),
        .headPtr_o    (headPtr_o),
        .exception_o  (exception_o),
        .excPtr_o     (excPtr_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: bench writes first, then the DUT's commit-side clears.
    always @(posedge clk) begin
        if (fill_all) begin
            for (int i = 0; i < 128; i++) ram[i] <= 2'b01;
        end
        if (set_en) ram[set_addr] <= set_val;
        for (int k = 0; k < 4; k++) begin
            if (clrWe_o[k]) ram[clrAddr_o[k*7 +: 7]] <= 2'b00;
        end
    end

    always_comb begin
        rdData_i = 8'd0;
        for (int k = 0; k < 4; k++) rdData_i[k*2 +: 2] = ram[rdAddr_o[k*7 +: 7]];
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input int addr, input logic [1:0] val);
        set_en   = 1'b1;
        set_addr = 7'(addr);
        set_val  = val;
        tick();
        set_en   = 1'b0;
    endtask

    task automatic set_range(input int lo, input int hi, input logic [1:0] val);
        for (int a = lo; a <= hi; a++) set_entry(a, val);
    endtask

    task automatic wait_ready(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (!ready_o && n < 200) begin
            tick();
            n++;
        end
        check_val(tag, 64'(n), 64'(exp_cycles));
    endtask

    function automatic int count_nonzero();
        int nz;
        nz = 0;
        for (int i = 0; i < 128; i++) if (ram[i] != 2'b00) nz++;
        return nz;
    endfunction

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
        alCount_i = 8'd0; laneActive_i = 4'b1111;
        fill_all = 1'b1; set_en = 1'b0; set_addr = 7'd0; set_val = 2'b00;
        tick();
        fill_all = 1'b0;
        tick();

        // Reset state and first sweep
        check_val("rst_ready", 64'(ready_o), 64'd0);
        check_val("rst_head", 64'(headPtr_o), 64'd0);
        check_val("rst_cnt", 64'(commitCnt_o), 64'd0);
        check_val("rst_vec", 64'(commitVec_o), 64'd0);
        check_val("rst_exc", 64'(exception_o), 64'd0);
        reset = 1'b0;
        #1;
        check_val("init_we", 64'(clrWe_o), 64'hF);
        check_val("init_addr", 64'(clrAddr_o), 64'({7'd3, 7'd2, 7'd1, 7'd0}));
        check_val("clr_data", 64'(clrData_o), 64'd0);
        wait_ready("init_len", 32);
        check_val("sweep_zero", 64'(count_nonzero()), 64'd0);
        check_val("run_head", 64'(headPtr_o), 64'd0);

        // Four-wide retire from head 0
        set_range(0, 3, 2'b01);
        alCount_i = 8'd6;
        #1;
        check_val("c4_rdaddr", 64'(rdAddr_o), 64'({7'd3, 7'd2, 7'd1, 7'd0}));
        check_val("c4_we", 64'(clrWe_o), 64'hF);
        check_val("c4_addr", 64'(clrAddr_o), 64'({7'd3, 7'd2, 7'd1, 7'd0}));
        tick();
        check_val("c4_head", 64'(headPtr_o), 64'd4);
        check_val("c4_cnt", 64'(commitCnt_o), 64'd4);
        check_val("c4_vec", 64'(commitVec_o), 64'hF);
        alCount_i = 8'd0;
        tick();
        check_val("idle_cnt", 64'(commitCnt_o), 64'd0);

        // Drain up to 126, then retire across the wrap
        set_range(4, 125, 2'b01);
        alCount_i = 8'd8;
        repeat (40) tick();
        check_val("drain_head", 64'(headPtr_o), 64'd126);
        alCount_i = 8'd0;
        set_entry(126, 2'b01);
        set_entry(127, 2'b01);
        set_entry(0, 2'b01);
        alCount_i = 8'd4;
        #1;
        check_val("wrap_we", 64'(clrWe_o), 64'h7);
        check_val("wrap_addr", 64'(clrAddr_o[20:0]), 64'({7'd0, 7'd127, 7'd126}));
        tick();
        check_val("wrap_head", 64'(headPtr_o), 64'd1);
        check_val("wrap_cnt", 64'(commitCnt_o), 64'd3);
        check_val("wrap_vec", 64'(commitVec_o), 64'h7);

        // Exception behind two ready entries at head 10
        alCount_i = 8'd0;
        set_range(1, 9, 2'b01);
        alCount_i = 8'd16;
        repeat (5) tick();
        check_val("pre_exc_head", 64'(headPtr_o), 64'd10);
        alCount_i = 8'd0;
        set_entry(10, 2'b01);
        set_entry(11, 2'b01);
        set_entry(12, 2'b11);
        alCount_i = 8'd8;
        #1;
        check_val("exc_pre_we", 64'(clrWe_o), 64'h3);
        tick();
        check_val("exc_pre_head", 64'(headPtr_o), 64'd12);
        check_val("exc_pre_cnt", 64'(commitCnt_o), 64'd2);
        check_val("exc_pre_vec", 64'(commitVec_o), 64'h3);
        check_val("exc_pre_flag", 64'(exception_o), 64'd0);
        check_val("exc_head_we", 64'(clrWe_o), 64'h0);
        tick();
        check_val("exc_flag", 64'(exception_o), 64'd1);
        check_val("exc_ptr", 64'(excPtr_o), 64'd12);
        check_val("exc_cnt", 64'(commitCnt_o), 64'd0);
        check_val("exc_ready", 64'(ready_o), 64'd1);
        tick();
        check_val("exc_hold", 64'(exception_o), 64'd1);
        check_val("exc_hold_head", 64'(headPtr_o), 64'd12);
        check_val("exc_hold_we", 64'(clrWe_o), 64'h0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        alCount_i = 8'd0;
        check_val("flush_ready", 64'(ready_o), 64'd0);
        check_val("flush_exc", 64'(exception_o), 64'd0);
        check_val("flush_head", 64'(headPtr_o), 64'd0);
        wait_ready("flush_len", 32);
        check_val("flush_zero", 64'(count_nonzero()), 64'd0);

        // Two active lanes with stall pulses, then alCount limiting
        set_range(0, 7, 2'b01);
        laneActive_i = 4'b0011;
        alCount_i = 8'd8;
        #1;
        check_val("l2_we", 64'(clrWe_o), 64'h3);
        tick();
        check_val("l2_cnt", 64'(commitCnt_o), 64'd2);
        check_val("l2_vec", 64'(commitVec_o), 64'h3);
        check_val("l2_head", 64'(headPtr_o), 64'd2);
        stall_i = 1'b1;
        #1;
        check_val("stall_we", 64'(clrWe_o), 64'h0);
        tick();
        check_val("stall_cnt", 64'(commitCnt_o), 64'd0);
        check_val("stall_head", 64'(headPtr_o), 64'd2);
        stall_i = 1'b0;
        tick();
        check_val("l2b_cnt", 64'(commitCnt_o), 64'd2);
        check_val("l2b_head", 64'(headPtr_o), 64'd4);
        laneActive_i = 4'b1111;
        alCount_i = 8'd1;
        tick();
        check_val("al1_cnt", 64'(commitCnt_o), 64'd1);
        check_val("al1_vec", 64'(commitVec_o), 64'h1);
        check_val("al1_head", 64'(headPtr_o), 64'd5);

        // Reset in the middle of a sweep
        alCount_i = 8'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        #1;
        check_val("mid_sweep_addr", 64'(clrAddr_o[6:0]), 64'd40);
        check_val("mid_sweep_ready", 64'(ready_o), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_val("restart_addr", 64'(clrAddr_o[6:0]), 64'd0);
        wait_ready("restart_len", 32);
        check_val("restart_head", 64'(headPtr_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/al_ready_commit.md
# al_ready_commit

- Commit-side reader and clearer for the active-list ready-bit RAM. Issue lanes set ready/exception bits; this block clears them.
- Each cycle it reads up to COMMIT_WIDTH ready bits starting at the active-list head and computes how many contiguous entries retire.
- It clears the retired entries through the RAM's commit write ports, advances the head, and reports exceptions.
- It sweeps the RAM to zero after reset or flush.

## Interface
- DEPTH, 128, active-list entries; power of two
- INDEX, 7, log2(DEPTH)
- COMMIT_WIDTH, 4, commit lanes, 1..4
- WIDTH, 2, bits per entry: bit0 ready, bit1 exception
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush_i  in  1  pipeline flush; restarts the clear sweep
- stall_i  in  1  commit backpressure; forces zero commits this cycle
- alCount_i  in  INDEX+1  valid entries in the active list
- laneActive_i  in  COMMIT_WIDTH  active commit lanes; contiguous from lane 0
- rdAddr_o  out  COMMIT_WIDTH×INDEX  read addresses to RAM read ports
- rdData_i  in  COMMIT_WIDTH×WIDTH  combinational read data
- clrWe_o  out  COMMIT_WIDTH  write enables to RAM commit write ports
- clrAddr_o  out  COMMIT_WIDTH×INDEX  clear addresses
- clrData_o  out  COMMIT_WIDTH×WIDTH  always zero
- commitVec_o  out  COMMIT_WIDTH  registered: lanes that retired last cycle
- commitCnt_o  out  3  registered popcount of commitVec_o
- headPtr_o  out  INDEX  current head
- exception_o  out  1  registered: head entry holds an exception
- excPtr_o  out  INDEX  index of the excepting entry
- ready_o  out  1  high only in RUN or EXC

## Operation
- States:
  - INIT: clear sweep.
  - RUN: normal retirement.
  - EXC: head entry has an exception; waiting for flush.
- reset or flush_i: next state INIT, sweepPtr=0, head=0, all registered outputs 0; any state, highest priority.
- INIT:
  - Each cycle drives clrWe_o=all active lanes, clrAddr_o[k]=sweepPtr+k, and advances sweepPtr by the number of active lanes.
  - When the sweep passes DEPTH-1, go to RUN.
  - No commits; rdAddr_o don't-care.
- RUN:
  - rdAddr_o[k] = (head+k) mod DEPTH.
  - n = min(alCount_i, popcount(laneActive_i)).
  - c = length of the contiguous prefix of entries k<n with bit0=1 and bit1=0.
  - If entry 0 has bit0=1 and bit1=1: c=0, next state EXC, exception_o=1, excPtr_o=head.
  - If stall_i: c=0 and no EXC transition.
  - Drive clrWe_o[k]=1 for k<c, with clrAddr_o[k]=head+k.
  - head <= (head+c) mod DEPTH. Wrap-around is natural INDEX-bit overflow.
  - commitVec_o <= prefix mask of c; commitCnt_o <= c.
- An excepting entry at k>0 stops the prefix at k. It becomes head next cycle and is reported then.
- A not-ready entry at k=0 gives c=0; the head holds.
- EXC: no reads, no clears, no commits. exception_o stays high until flush_i.
- A simultaneous issue write and commit read to the same entry returns the old RAM value and is picked up next cycle.
- A clear and an issue write never target the same entry: commit-side clears hit only retired entries.
- A laneActive_i change takes effect in the same cycle.

## Timing
- Read and decision are combinational within the cycle. Clears and the head update land at the clock edge.
- Throughput is one commit group per cycle.
- commitVec_o, commitCnt_o and exception_o lag the retiring cycle by 1.
- Sweep length is ceil(DEPTH / active lanes) cycles: 32 for DEPTH=128 with 4 lanes.
- After reset, ready_o rises on the first RUN cycle.
- Reset in the middle of a sweep restarts it from sweepPtr=0.
- Reset values: every output 0; headPtr_o=0; clrData_o=0 always.

## Structure
- Shared package:
  - AL_READY_BIT=0, AL_EXC_BIT=1.
  - alCommitState_t enum {INIT, RUN, EXC}.
  - Commit-count width constant.
- Sub-module al_ready_prefix: purely combinational. Takes the entries, n and stall; returns c, the clear mask and the exception flag.
- The top level holds the FSM, head pointer, sweep pointer and output registers.

## Test plan
- Reset, 4 lanes → 32 INIT cycles each writing 4 zeros; ready_o rises on cycle 33; headPtr_o=0.
- head=0, alCount_i=6, entries 0-3 ready → clears 0-3, head=4, next cycle commitCnt_o=4, commitVec_o=4'b1111.
- head=126, alCount_i=4, entries 126,127,0 ready, entry 1 not ready → clears 126,127,0; head=1; commitCnt_o=3.
- head=10, entries 10 and 11 ready, 12 ready with exception → commit 2; next cycle head=12, exception_o=1, excPtr_o=12, no further commits; flush_i → INIT.
- laneActive_i=4'b0011 and stall_i pulses with all entries ready → at most 2 commits per cycle; 0 during stall cycles.
- Reset asserted at sweep cycle 10 → sweep restarts at 0; full 32 cycles before ready_o.
